// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU-side types for memory arbitration.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGNT, DGNT, FAULT} arb_state_t;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: picks the next grant from IDLE with data priority and starvation guard.
module mem_arb_select
    import cpu_types_pkg::*;
#(
    parameter int DATA_STREAK_MAX = 4,
    parameter int SW = 3
) (
    input  logic          iREN,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [SW-1:0] streak,
    output arb_state_t    nxt,
    output logic          wen
);
    logic starve;
    always_comb begin
        starve = iREN && streak == SW'(DATA_STREAK_MAX);
        nxt = ((dREN || dWEN) && !starve) ? DGNT : iREN ? IGNT : IDLE;
        wen = dWEN;
    end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM arbiter between instruction and data requesters
// with streak-based fairness, grant timeout and sticky fault.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int RAM_TIMEOUT = 16,
    parameter int DATA_STREAK_MAX = 4
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    input  ramstate_t ramstate,
    input  word_t     ramload,
    output logic      ihit,
    output logic      dhit,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    output logic      fault
);
    localparam int SW = $clog2(DATA_STREAK_MAX + 1);
    localparam int TW = $clog2(RAM_TIMEOUT + 1);
    arb_state_t    state_q, state_d, sel_nxt;
    word_t         addr_q, addr_d, store_q, store_d;
    logic          wen_q, wen_d, sel_wen, grant;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    mem_arb_select #(.DATA_STREAK_MAX(DATA_STREAK_MAX), .SW(SW)) u_sel (
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .streak(streak_q),
        .nxt(sel_nxt), .wen(sel_wen)
    );
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wen_d    = wen_q;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        case (state_q)
            IDLE: if (sel_nxt != IDLE) begin
                state_d  = sel_nxt;
                tmo_d    = '0;
                addr_d   = sel_nxt == DGNT ? daddr : iaddr;
                store_d  = sel_nxt == DGNT ? dstore : '0;
                wen_d    = sel_nxt == DGNT && sel_wen;
                streak_d = sel_nxt == IGNT ? '0 :
                           streak_q == SW'(DATA_STREAK_MAX) ? streak_q : streak_q + SW'(1);
            end
            IGNT, DGNT: begin
                if (ramstate == ACCESS) state_d = IDLE;
                else if (ramstate == ERROR) state_d = FAULT;
                else begin
                    tmo_d = tmo_q + TW'(1);
                    if (tmo_q == TW'(RAM_TIMEOUT - 1)) state_d = FAULT;
                end
            end
            default: state_d = FAULT;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            wen_q    <= 1'b0;
            streak_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            store_q  <= store_d;
            wen_q    <= wen_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
        end
    end
    // Strobes and address decode only from the latched request, never live inputs.
    always_comb begin
        grant    = state_q == IGNT || state_q == DGNT;
        ramREN   = state_q == IGNT || (state_q == DGNT && !wen_q);
        ramWEN   = state_q == DGNT && wen_q;
        ramaddr  = grant ? addr_q : '0;
        ramstore = grant ? store_q : '0;
        ihit     = state_q == IGNT && ramstate == ACCESS;
        dhit     = state_q == DGNT && ramstate == ACCESS;
        iload    = ihit ? ramload : '0;
        dload    = (dhit && !wen_q) ? ramload : '0;
        fault    = state_q == FAULT;
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed-vector bench for memory_arbiter.
module tb_memory_arbiter;
    import cpu_types_pkg::*;
    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    word_t     iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    ramstate_t ramstate = FREE;
    logic      ihit, dhit, ramREN, ramWEN, fault;
    word_t     iload, dload, ramaddr, ramstore;
    int        vectors = 0, miscompares = 0;
    memory_arbiter dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .ramREN(ramREN),
        .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .fault(fault)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(negedge CLK);
        #1;
    endtask
    initial begin
        tick;
        tick;
        chk("rst_fault", 32'(fault), 0);
        chk("rst_ren", 32'(ramREN), 0);
        chk("rst_wen", 32'(ramWEN), 0);
        chk("rst_hits", {30'd0, ihit, dhit}, 0);
        chk("rst_addr", ramaddr, 0);
        RST = 1'b0;
        // Instruction read with two BUSY cycles
        iREN = 1'b1; iaddr = 32'h40; ramstate = BUSY;
        #1 chk("i_idle_ren", 32'(ramREN), 0);
        tick;
        iREN = 1'b0; iaddr = 32'h999;
        #1;
        chk("i_b1_ren", 32'(ramREN), 1);
        chk("i_b1_addr", ramaddr, 32'h40);
        chk("i_b1_hit", 32'(ihit), 0);
        tick;
        chk("i_b2_ren", 32'(ramREN), 1);
        chk("i_b2_hit", 32'(ihit), 0);
        chk("i_b2_iload", iload, 0);
        tick;
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        #1;
        chk("i_acc_ren", 32'(ramREN), 1);
        chk("i_acc_addr", ramaddr, 32'h40);
        chk("i_acc_hit", 32'(ihit), 1);
        chk("i_acc_iload", iload, 32'hDEADBEEF);
        tick;
        ramstate = FREE;
        #1;
        chk("i_done_hit", 32'(ihit), 0);
        chk("i_done_iload", iload, 0);
        chk("i_done_ren", 32'(ramREN), 0);
        // Simultaneous instruction read and data write: data first
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h5; iaddr = 32'h44;
        tick;
        dWEN = 1'b0; ramstate = ACCESS;
        #1;
        chk("dw_wen", 32'(ramWEN), 1);
        chk("dw_ren", 32'(ramREN), 0);
        chk("dw_store", ramstore, 32'h5);
        chk("dw_addr", ramaddr, 32'h100);
        chk("dw_dhit", 32'(dhit), 1);
        chk("dw_dload", dload, 0);
        tick;
        chk("dw_idle_hits", {30'd0, ihit, dhit}, 0);
        chk("dw_idle_wen", 32'(ramWEN), 0);
        tick;
        iREN = 1'b0; ramload = 32'h1234;
        #1;
        chk("iw_ihit", 32'(ihit), 1);
        chk("iw_iload", iload, 32'h1234);
        chk("iw_addr", ramaddr, 32'h44);
        chk("iw_ren", 32'(ramREN), 1);
        tick;
        // Both held: four data grants then one instruction grant, repeating
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h80; ramload = 32'hA5A5A5A5;
        for (int g = 0; g < 10; g++) begin
            tick;
            chk($sformatf("fair%0d_dhit", g), 32'(dhit), (g % 5 != 4) ? 1 : 0);
            chk($sformatf("fair%0d_ihit", g), 32'(ihit), (g % 5 == 4) ? 1 : 0);
            chk($sformatf("fair%0d_addr", g), ramaddr, (g % 5 == 4) ? 32'h80 : 32'h200);
            tick;
        end
        dREN = 1'b0; iREN = 1'b0;
        tick;
        // Timeout: BUSY forever
        dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
        tick;
        dREN = 1'b0;
        for (int g = 1; g <= 16; g++) begin
            chk($sformatf("to%0d_ren", g), 32'(ramREN), 1);
            chk($sformatf("to%0d_dhit", g), 32'(dhit), 0);
            chk($sformatf("to%0d_fault", g), 32'(fault), 0);
            tick;
        end
        chk("to_fault", 32'(fault), 1);
        chk("to_strobes", {30'd0, ramREN, ramWEN}, 0);
        iREN = 1'b1; ramstate = ACCESS;
        tick;
        tick;
        chk("to_sticky", 32'(fault), 1);
        chk("to_nohit", {30'd0, ihit, dhit}, 0);
        chk("to_nostrobe", {30'd0, ramREN, ramWEN}, 0);
        iREN = 1'b0; RST = 1'b1;
        tick;
        RST = 1'b0;
        #1 chk("to_rst_fault", 32'(fault), 0);
        // ERROR during data grant
        dREN = 1'b1; daddr = 32'h400; ramstate = BUSY;
        tick;
        dREN = 1'b0; ramstate = ERROR;
        #1;
        chk("er_ren", 32'(ramREN), 1);
        chk("er_dhit", 32'(dhit), 0);
        tick;
        chk("er_fault", 32'(fault), 1);
        chk("er_dhit2", 32'(dhit), 0);
        chk("er_ren2", 32'(ramREN), 0);
        RST = 1'b1;
        tick;
        RST = 1'b0; ramstate = FREE;
        // Reset mid data grant
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h500; dstore = 32'h7; ramstate = BUSY;
        tick;
        dWEN = 1'b0; dREN = 1'b0;
        #1;
        chk("rg_wen", 32'(ramWEN), 1);
        chk("rg_ren", 32'(ramREN), 0);
        chk("rg_store", ramstore, 32'h7);
        RST = 1'b1;
        tick;
        ramstate = ACCESS;
        #1;
        chk("rg_wen_off", 32'(ramWEN), 0);
        chk("rg_dhit", 32'(dhit), 0);
        chk("rg_fault", 32'(fault), 0);
        chk("rg_addr", ramaddr, 0);
        RST = 1'b0;
        tick;
        dREN = 1'b1; daddr = 32'h600; ramstate = FREE;
        tick;
        dREN = 1'b0; ramstate = ACCESS; ramload = 32'hCAFE;
        #1;
        chk("rf_dhit", 32'(dhit), 1);
        chk("rf_dload", dload, 32'hCAFE);
        chk("rf_addr", ramaddr, 32'h600);
        chk("rf_ren", 32'(ramREN), 1);
        tick;
        chk("rf_dhit_off", 32'(dhit), 0);
        chk("rf_dload_off", dload, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter RAM_TIMEOUT, default 16, meaning cycles a granted request may wait for ACCESS before fault.
REQ-002 SHALL have parameter DATA_STREAK_MAX, default 4, meaning consecutive data grants allowed before a pending instruction request wins.
REQ-003 SHALL have port CLK  in  1  system clock; all state on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port iREN  in  1  instruction read request.
REQ-006 SHALL have port iaddr  in  32  instruction word address.
REQ-007 SHALL have port dREN  in  1  data read request (request-unit dMemREN).
REQ-008 SHALL have port dWEN  in  1  data write request (request-unit dMemWEN).
REQ-009 SHALL have port daddr  in  32  data address.
REQ-010 SHALL have port dstore  in  32  data write value.
REQ-011 SHALL have port ramstate  in  ramstate_t  RAM status: FREE/BUSY/ACCESS/ERROR.
REQ-012 SHALL have port ramload  in  32  RAM read data.
REQ-013 SHALL have port ihit  out  1  instruction access complete (one-cycle pulse).
REQ-014 SHALL have port dhit  out  1  data access complete (one-cycle pulse).
REQ-015 SHALL have port iload / dload  out  32 each  read data returned with hit.
REQ-016 SHALL have port ramREN / ramWEN  out  1 each  RAM strobes.
REQ-017 SHALL have port ramaddr / ramstore  out  32 each  RAM address / write data.
REQ-018 SHALL have port fault  out  1  sticky error flag.

Function
REQ-019 SHALL implement FSM states IDLE, IGNT, DGNT, FAULT.
REQ-020 IDLE: SHALL register request (addr, store, write bit) and move to DGNT if dREN|dWEN, else IGNT if iREN, else stay.
REQ-021 Starvation: SHALL move to IGNT instead of DGNT when iREN=1 and streak counter == DATA_STREAK_MAX.
REQ-022 Streak counter: SHALL increment on each DGNT entry (saturating at DATA_STREAK_MAX); SHALL clear on IGNT entry.
REQ-023 dREN&dWEN both high: SHALL treat as write.
REQ-024 In IGNT/DGNT: SHALL drive ramaddr/ramstore/ramREN/ramWEN from registered values only, never from live inputs.
REQ-025 Ram strobes: SHALL be zero in IDLE and FAULT; exactly one of ramREN/ramWEN SHALL be high in a grant state.
REQ-026 Completion: cycle with ramstate==ACCESS in grant state SHALL assert matching hit combinationally, drive load=ramload (reads), next state IDLE.
REQ-027 Loads: iload/dload SHALL be zero whenever their hit is low.
REQ-028 Latency: request in IDLE cycle N -> ram strobes from cycle N+1; minimum hit at cycle N+1.
REQ-029 Back-to-back: requester still asserting after hit SHALL be re-granted as new request; requester (request unit) owns deassertion.
REQ-030 Timeout: counter SHALL clear on grant entry, count each grant cycle without ACCESS; reaching RAM_TIMEOUT SHALL go to FAULT.
REQ-031 ramstate==ERROR in grant state SHALL go to FAULT next cycle, no hit.
REQ-032 FAULT: SHALL hold fault=1, no hits, no strobes, until RST.
REQ-033 Requests changing mid-grant SHALL NOT affect the in-flight access.

Reset
REQ-034 RST=1 SHALL force IDLE, clear streak/timeout counters and latched request, fault=0, all outputs 0, on next edge.
REQ-035 RST mid-grant SHALL abandon the access with no hit issued.

Structure
REQ-036 ramstate_t and word_t SHALL come from cpu_types_pkg; arb_state_t enum SHALL be added to cpu_types_pkg.
REQ-037 Next-grant selection (REQ-020..023) SHALL be a combinational sub-module mem_arb_select.
REQ-038 Implementation SHALL be one FSM block plus counters, 120-400 lines.

Verification
REQ-039 iREN=1, iaddr=0x40, ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> ramREN high 3 cycles, ramaddr=0x40, ihit one pulse with iload=0xDEADBEEF.
REQ-040 iREN and dWEN same cycle, daddr=0x100, dstore=0x5 -> DGNT first: ramWEN=1, ramstore=0x5, dhit; then IGNT, ihit.
REQ-041 dREN and iREN held continuously, ACCESS every grant -> 4 dhits then 1 ihit, repeating.
REQ-042 Grant with ramstate stuck BUSY -> fault=1 after 16 grant cycles, no hit, strobes 0; stays until RST.
REQ-043 ramstate=ERROR during DGNT -> FAULT next cycle, dhit never asserted.
REQ-044 RST pulsed during DGNT before ACCESS -> IDLE, outputs 0, fault=0, no dhit; fresh request proceeds normally.
